// File: rtl/target_sequencer_if.sv
// Waypoint-push, control and axis-controller signals shared by the target
// sequencer and whatever drives it.
interface target_sequencer_if #(
    parameter int DEPTH   = 16,
    parameter int DWELL_W = 24
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic               wr_en;
    logic [31:0]        wr_target;
    logic [DWELL_W-1:0] wr_dwell;
    logic               start;
    logic               abort;
    logic               motor_done;
    logic [3:0]         motor_status;
    logic [31:0]        location;
    logic [31:0]        target;
    logic               axis_enable;
    logic               full;
    logic               empty;
    logic [LW-1:0]      level;
    logic               busy;
    logic               seq_done;
    logic               error;
    logic [3:0]         error_code;
    logic [2:0]         state;

    modport master (
        output wr_en, wr_target, wr_dwell, start, abort,
               motor_done, motor_status, location,
        input  target, axis_enable, full, empty, level,
               busy, seq_done, error, error_code, state
    );

    modport slave (
        input  wr_en, wr_target, wr_dwell, start, abort,
               motor_done, motor_status, location,
        output target, axis_enable, full, empty, level,
               busy, seq_done, error, error_code, state
    );
endinterface

// File: rtl/target_sequencer.sv
// Queues {target, dwell} waypoints and steps an axis controller through them,
// waiting for arrival and dwelling at each before moving on.
module target_sequencer #(
    parameter int DEPTH   = 16,
    parameter int DWELL_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    target_sequencer_if.slave   bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int EW = 32 + DWELL_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_LEAVE  = 3'd2,
        S_ARRIVE = 3'd3,
        S_DWELL  = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    logic               done_meta_q, done_s_q;
    logic [3:0]         status_meta_q, status_s_q;
    logic [EW-1:0]      fifo_mem [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic               full_q, full_d, empty_q, empty_d;
    state_t             state_q, state_d;
    logic [31:0]        target_q, target_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               axis_enable_q, axis_enable_d;
    logic               busy_q, busy_d;
    logic               seq_done_q, seq_done_d;
    logic               error_q, error_d;
    logic [3:0]         error_code_q, error_code_d;
    logic               match_q, match_d;

    logic               push_s, pop_s, at_target_s, match_s, fault_s;
    logic [EW-1:0]      head_s;

    // Two-flop synchronisers for the axis controller's asynchronous flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_meta_q   <= 1'b0;
            done_s_q      <= 1'b0;
            status_meta_q <= 4'b0000;
            status_s_q    <= 4'b0000;
        end else begin
            done_meta_q   <= bus.motor_done;
            done_s_q      <= done_meta_q;
            status_meta_q <= bus.motor_status;
            status_s_q    <= status_meta_q;
        end
    end

    assign push_s = bus.wr_en & ~full_q & ~bus.abort;
    assign pop_s  = (state_q == S_LOAD) & ~empty_q & ~bus.abort;
    assign head_s = fifo_mem[rd_ptr_q];

    // Waypoint storage; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem[wr_ptr_q] <= {bus.wr_target, bus.wr_dwell};
        end
    end

    // Queue pointers and level; abort flushes and wins over a same-cycle push.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (bus.abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            level_d = level_q + LW'(push_s) - LW'(pop_s);
        end
        full_d  = (level_d == LW'(DEPTH));
        empty_d = (level_d == LW'(0));
    end

    assign at_target_s = (bus.location == target_q);
    assign match_s     = done_s_q & at_target_s;
    assign fault_s     = (status_s_q == 4'b1000) || (status_s_q == 4'b0001);

    // Sequencer next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        dwell_d       = dwell_q;
        axis_enable_d = axis_enable_q;
        seq_done_d    = 1'b0;
        error_d       = error_q;
        error_code_d  = error_code_q;
        match_d       = match_q;
        if (bus.abort) begin
            state_d       = S_IDLE;
            axis_enable_d = 1'b0;
            error_d       = 1'b0;
            error_code_d  = 4'b0000;
            match_d       = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start && !empty_q) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_LOAD: begin
                    if (!empty_q) begin
                        target_d      = head_s[EW-1:DWELL_W];
                        dwell_d       = head_s[DWELL_W-1:0];
                        axis_enable_d = 1'b1;
                        match_d       = 1'b0;
                        state_d       = S_LEAVE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_LEAVE: begin
                    // A zero-length move never drops Done, so two settled cycles stand in for it.
                    match_d = match_s;
                    if (fault_s) begin
                        state_d       = S_ERROR;
                        error_d       = 1'b1;
                        error_code_d  = status_s_q;
                        axis_enable_d = 1'b0;
                    end else if (!done_s_q) begin
                        state_d = S_ARRIVE;
                    end else if (match_s && match_q) begin
                        state_d = S_DWELL;
                    end else begin
                        state_d = S_LEAVE;
                    end
                end
                S_ARRIVE: begin
                    if (fault_s) begin
                        state_d       = S_ERROR;
                        error_d       = 1'b1;
                        error_code_d  = status_s_q;
                        axis_enable_d = 1'b0;
                    end else if (match_s) begin
                        state_d = S_DWELL;
                    end else begin
                        state_d = S_ARRIVE;
                    end
                end
                S_DWELL: begin
                    if (fault_s) begin
                        state_d       = S_ERROR;
                        error_d       = 1'b1;
                        error_code_d  = status_s_q;
                        axis_enable_d = 1'b0;
                    end else if (dwell_q == DWELL_W'(0)) begin
                        if (!empty_q) begin
                            state_d = S_LOAD;
                        end else begin
                            state_d    = S_IDLE;
                            seq_done_d = 1'b1;
                        end
                    end else begin
                        dwell_d = dwell_q - DWELL_W'(1);
                    end
                end
                S_ERROR: begin
                    error_d       = 1'b1;
                    axis_enable_d = 1'b0;
                    state_d       = S_ERROR;
                end
                default: begin
                    state_d       = S_IDLE;
                    axis_enable_d = 1'b0;
                end
            endcase
        end
        busy_d = (state_d == S_LOAD) || (state_d == S_LEAVE) ||
                 (state_d == S_ARRIVE) || (state_d == S_DWELL);
    end

    // State, queue bookkeeping and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            state_q       <= S_IDLE;
            target_q      <= 32'd0;
            dwell_q       <= '0;
            axis_enable_q <= 1'b0;
            busy_q        <= 1'b0;
            seq_done_q    <= 1'b0;
            error_q       <= 1'b0;
            error_code_q  <= 4'b0000;
            match_q       <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            state_q       <= state_d;
            target_q      <= target_d;
            dwell_q       <= dwell_d;
            axis_enable_q <= axis_enable_d;
            busy_q        <= busy_d;
            seq_done_q    <= seq_done_d;
            error_q       <= error_d;
            error_code_q  <= error_code_d;
            match_q       <= match_d;
        end
    end

    assign bus.target      = target_q;
    assign bus.axis_enable = axis_enable_q;
    assign bus.full        = full_q;
    assign bus.empty       = empty_q;
    assign bus.level       = level_q;
    assign bus.busy        = busy_q;
    assign bus.seq_done    = seq_done_q;
    assign bus.error       = error_q;
    assign bus.error_code  = error_code_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_target_sequencer.sv
// Directed bench for target_sequencer: a behavioural axis model plus a queue
// of expected targets checked whenever the sequencer starts a new move.
module tb_target_sequencer;
    localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_LEAVE = 3'd2,
                           S_ARRIVE = 3'd3, S_DWELL = 3'd4, S_ERROR = 3'd5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #10 clk = ~clk;

    target_sequencer_if #(.DEPTH(16), .DWELL_W(24)) ifc ();

    target_sequencer #(.DEPTH(16), .DWELL_W(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic [2:0]  prev_state  = 3'd0;
    int          mv_cnt      = 0;
    bit          motor_auto  = 1'b0;
    int          sd_cnt      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample after the edge, score new moves, run the axis model.
    task automatic cycle();
        logic [31:0] exp_t;
        @(posedge clk);
        #1;
        if (ifc.seq_done === 1'b1) sd_cnt++;
        if (ifc.state == S_LEAVE && prev_state != S_LEAVE) begin
            exp_t = 32'hFFFF_FFFF;
            if (exp_q.size() > 0) exp_t = exp_q.pop_front();
            check("sb_target", ifc.target, exp_t);
            if (motor_auto) begin
                ifc.motor_done = 1'b0;
                mv_cnt = 6;
            end
        end else if (motor_auto && mv_cnt > 0) begin
            mv_cnt--;
            if (mv_cnt == 0) begin
                ifc.location   = ifc.target;
                ifc.motor_done = 1'b1;
            end
        end
        prev_state = ifc.state;
    endtask

    task automatic push(input logic [31:0] t, input logic [23:0] d);
        ifc.wr_en     = 1'b1;
        ifc.wr_target = t;
        ifc.wr_dwell  = d;
        exp_q.push_back(t);
        cycle();
        ifc.wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        ifc.start = 1'b1;
        cycle();
        ifc.start = 1'b0;
    endtask

    task automatic pulse_abort();
        ifc.abort = 1'b1;
        cycle();
        ifc.abort = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        for (int i = 0; i < budget && ifc.state != s; i++) cycle();
        check(tag, ifc.state, s);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, ifc.state, S_IDLE);
        check({tag, "_level"}, ifc.level, 0);
        check({tag, "_empty"}, ifc.empty, 1);
        check({tag, "_full"}, ifc.full, 0);
        check({tag, "_target"}, ifc.target, 0);
        check({tag, "_axis_en"}, ifc.axis_enable, 0);
        check({tag, "_busy"}, ifc.busy, 0);
        check({tag, "_seq_done"}, ifc.seq_done, 0);
        check({tag, "_error"}, ifc.error, 0);
        check({tag, "_err_code"}, ifc.error_code, 0);
    endtask

    initial begin
        ifc.wr_en = 1'b0; ifc.wr_target = 32'd0; ifc.wr_dwell = 24'd0;
        ifc.start = 1'b0; ifc.abort = 1'b0;
        ifc.motor_done = 1'b1; ifc.motor_status = 4'b0000; ifc.location = 32'd0;

        // Reset values while rst is held low.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        #4 rst = 1'b1;
        cycle(); cycle();

        // Three waypoints executed end to end.
        motor_auto = 1'b1;
        push(32'd100, 24'd10);
        push(32'd500, 24'd0);
        push(32'd200, 24'd5);
        check("seq_level3", ifc.level, 3);
        sd_cnt = 0;
        pulse_start();
        check("seq_load", ifc.state, S_LOAD);
        check("seq_busy", ifc.busy, 1);
        for (int i = 0; i < 300; i++) cycle();
        check("seq_all_targets", exp_q.size(), 0);
        check("seq_done_once", sd_cnt, 1);
        check("seq_empty", ifc.empty, 1);
        check("seq_idle", ifc.state, S_IDLE);
        check("seq_not_busy", ifc.busy, 0);
        check("seq_hold_target", ifc.target, 200);
        check("seq_hold_enable", ifc.axis_enable, 1);

        // Fill beyond capacity: the 17th push is dropped.
        for (int i = 0; i < 17; i++) begin
            push(32'(1000 + i), 24'd1);
            if (i == 14) begin
                check("fill15_full", ifc.full, 0);
                check("fill15_level", ifc.level, 15);
            end
            if (i == 15) begin
                check("fill16_full", ifc.full, 1);
                check("fill16_level", ifc.level, 16);
            end
        end
        check("fill17_full", ifc.full, 1);
        check("fill17_level", ifc.level, 16);
        check("fill17_empty", ifc.empty, 0);
        pulse_abort();
        check("flush_level", ifc.level, 0);
        check("flush_empty", ifc.empty, 1);
        check("flush_full", ifc.full, 0);

        // Zero-length move with Done held high.
        motor_auto = 1'b0; mv_cnt = 0;
        ifc.location = 32'd300; ifc.motor_done = 1'b1;
        cycle(); cycle(); cycle();
        push(32'd300, 24'd2);
        pulse_start();
        check("zl_load", ifc.state, S_LOAD);
        cycle(); check("zl_leave1", ifc.state, S_LEAVE);
        cycle(); check("zl_leave2", ifc.state, S_LEAVE);
        cycle(); check("zl_dwell", ifc.state, S_DWELL);
        wait_state(S_IDLE, 20, "zl_idle");

        // Limit fault while arriving, then abort.
        motor_auto = 1'b1;
        push(32'd700, 24'd0);
        push(32'd800, 24'd0);
        pulse_start();
        wait_state(S_ARRIVE, 20, "flt_arrive");
        motor_auto = 1'b0;
        ifc.motor_status = 4'b1000;
        wait_state(S_ERROR, 10, "flt_error_state");
        check("flt_error", ifc.error, 1);
        check("flt_code", ifc.error_code, 4'b1000);
        check("flt_axis_en", ifc.axis_enable, 0);
        check("flt_not_busy", ifc.busy, 0);
        ifc.motor_status = 4'b0000;
        cycle(); cycle(); cycle();
        check("flt_hold", ifc.state, S_ERROR);
        pulse_abort();
        check("flt_abort_state", ifc.state, S_IDLE);
        check("flt_abort_level", ifc.level, 0);
        check("flt_abort_error", ifc.error, 0);
        check("flt_abort_code", ifc.error_code, 0);

        // Abort with a simultaneous push while dwelling.
        mv_cnt = 0;
        ifc.location = 32'd900; ifc.motor_done = 1'b1;
        cycle(); cycle(); cycle();
        push(32'd900, 24'd50);
        push(32'd950, 24'd0);
        pulse_start();
        wait_state(S_DWELL, 20, "ab_dwell");
        ifc.abort = 1'b1; ifc.wr_en = 1'b1; ifc.wr_target = 32'd1234; ifc.wr_dwell = 24'd3;
        cycle();
        ifc.abort = 1'b0; ifc.wr_en = 1'b0;
        exp_q.delete();
        check("ab_level", ifc.level, 0);
        check("ab_state", ifc.state, S_IDLE);
        check("ab_empty", ifc.empty, 1);
        check("ab_axis_en", ifc.axis_enable, 0);

        // Reset pulsed mid-move.
        motor_auto = 1'b1;
        push(32'd1000, 24'd0);
        push(32'd1100, 24'd0);
        pulse_start();
        wait_state(S_ARRIVE, 20, "mr_arrive");
        rst = 1'b0;
        #1;
        check_reset_outputs("mr");
        #3 rst = 1'b1;
        exp_q.delete();
        motor_auto = 1'b0; mv_cnt = 0;
        cycle();
        pulse_start();
        cycle();
        check("mr_start_state", ifc.state, S_IDLE);
        check("mr_start_busy", ifc.busy, 0);
        check("mr_start_level", ifc.level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/target_sequencer.md
TARGET_SEQUENCER -- requirements
Module: target_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, queue entries (power of 2, 2..256).
REQ-002 SHALL have parameter DWELL_W, default 24, dwell counter width in bits.
REQ-003 SHALL have port clk  input  1  system clock, 50 MHz.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports wr_en  input  1, wr_target  input  32, wr_dwell  input  DWELL_W; together they push one waypoint (target position, post-arrival dwell in clk cycles).
REQ-006 SHALL have ports start  input  1 (begin executing the queue) and abort  input  1 (stop and flush).
REQ-007 SHALL have ports motor_done  input  1 and motor_status  input  4, both asynchronous to clk; they carry the axis controller's Done flag and StatusCode.
REQ-008 SHALL have port location  input  32, the axis controller's current position.
REQ-009 SHALL have ports target  output  32 and axis_enable  output  1; these drive the axis controller's Target input and its CR enable bit.
REQ-010 SHALL have ports full, empty  output  1 each and level  output  $clog2(DEPTH)+1.
REQ-011 SHALL have ports busy  output  1, seq_done  output  1 (one-cycle pulse), error  output  1, error_code  output  4, state  output  3.

Function
REQ-012 SHALL synchronise motor_done and motor_status through 2-flop synchronisers; done_s and status_s denote the synchronised values.
REQ-013 SHALL implement the queue as a FIFO of {target, dwell}, with DEPTH entries and a registered level.
REQ-014 SHALL ignore a push when full, and leave level unchanged on the same cycle.
REQ-015 SHALL, when a push and an internal pop occur in the same cycle, apply both, leaving level unchanged.
REQ-016 SHALL use a state machine with states IDLE=0, LOAD=1, LEAVE=2, ARRIVE=3, DWELL=4, ERROR=5, reported on state.
REQ-017 SHALL transition IDLE->LOAD on start=1 with empty=0; start while empty SHALL be ignored.
REQ-018 SHALL, in LOAD: pop one entry, register target and dwell, assert axis_enable, then go to LEAVE on the next cycle.
REQ-019 SHALL, in LEAVE: go to ARRIVE when done_s=0. If done_s=1 and location==target for 2 consecutive cycles (zero-length move), it SHALL go directly to DWELL.
REQ-020 SHALL, in ARRIVE: go to DWELL when done_s=1 and location==target, both in the same cycle.
REQ-021 SHALL, in DWELL: count dwell down to 0 (dwell=0 means 1 cycle in DWELL), then go to LOAD if empty=0. Otherwise it SHALL go to IDLE and pulse seq_done for 1 cycle.
REQ-022 SHALL, in LEAVE, ARRIVE or DWELL, go to ERROR with error_code=status_s when status_s is 4'b1000 (target over upper limit) or 4'b0001 (target under lower limit).
REQ-023 SHALL, in ERROR: hold error=1 and axis_enable=0, and leave only on abort.
REQ-024 SHALL, on abort in any state: flush the FIFO (level=0), clear error and error_code, deassert axis_enable, and go to IDLE on the next cycle. Abort SHALL take priority over start and over a simultaneous push.
REQ-025 SHALL keep target and axis_enable unchanged on return to IDLE through normal completion (axis holds position).
REQ-026 SHALL drive busy=1 in states LOAD, LEAVE, ARRIVE and DWELL.
REQ-027 SHALL ignore start while busy.
REQ-028 SHALL perform all comparisons unsigned, 32-bit.

Reset
REQ-029 SHALL, while rst=0, asynchronously force:
- state=IDLE, level=0, empty=1, full=0;
- target=0, axis_enable=0, busy=0, seq_done=0, error=0, error_code=0;
- dwell counter=0, synchronisers=0.
REQ-030 SHALL lose all queued waypoints on reset asserted mid-move; operation SHALL resume only after a new push and start.
REQ-031 SHALL register all outputs, with no combinational path from input to output.

Verification
REQ-032 SHALL cover: push 3 waypoints (100/dwell 10, 500/0, 200/5), start, and model the motor. Required: target sequence 100,500,200; seq_done pulses once; empty=1.
REQ-033 SHALL cover: DEPTH=16, push 17 entries. Required: full=1 after the 16th push, level=16, the 17th push dropped.
REQ-034 SHALL cover: waypoint target equals location with motor_done held at 1. Required: DWELL entered after LEAVE (2-cycle check), no hang.
REQ-035 SHALL cover: motor_status=4'b1000 during ARRIVE. Required: error=1, error_code=4'b1000, axis_enable=0; then abort gives state=IDLE, level=0.
REQ-036 SHALL cover: abort and wr_en in the same cycle while in DWELL. Required: level=0, state=IDLE next cycle.
REQ-037 SHALL cover: rst pulsed low during ARRIVE. Required: immediate IDLE with every output at its reset value; start with empty=1 afterwards stays in IDLE.
